// File: rtl/and_2.sv
// Two-input bitwise AND with a combinational output and a registered copy that has rise/fall pulses.
// Define AND2_STATS_EN to enable the saturating hi_cnt counter; otherwise hi_cnt is tied to 0.
module and_2 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [CNT_W-1:0] hi_cnt
);

  assign Y = A & B;

  // Edge pulses compare the new sample against the pre-edge Y_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y_q  <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      Y_q  <= Y;
      rise <= Y & ~Y_q;
      fall <= ~Y & Y_q;
    end
  end

`ifdef AND2_STATS_EN
  logic [CNT_W-1:0] cnt_reg;

  // Counts edges with lane 0 high; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (Y[0] && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign hi_cnt = cnt_reg;
`else
  assign hi_cnt = '0;
`endif

endmodule

// File: tb/tb_and_2.sv
// Directed self-checking bench for and_2 (WIDTH=2, CNT_W=3); hi_cnt expectations follow AND2_STATS_EN.
module tb_and_2;

  logic       clk;
  logic       rst;
  logic [1:0] A;
  logic [1:0] B;
  logic [1:0] Y;
  logic [1:0] Y_q;
  logic [1:0] rise;
  logic [1:0] fall;
  logic [2:0] hi_cnt;

  int checks = 0;
  int errors = 0;

  and_2 #(.WIDTH(2), .CNT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .Y      (Y),
    .Y_q    (Y_q),
    .rise   (rise),
    .fall   (fall),
    .hi_cnt (hi_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] cnt_exp(input int v);
`ifdef AND2_STATS_EN
    return 3'(v);
`else
    return 3'(v * 0);
`endif
  endfunction

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] yq, input logic [1:0] r,
                           input logic [1:0] f, input int cnt);
    check({tag, ".Y_q"}, 16'(Y_q), 16'(yq));
    check({tag, ".rise"}, 16'(rise), 16'(r));
    check({tag, ".fall"}, 16'(fall), 16'(f));
    check({tag, ".hi_cnt"}, 16'(hi_cnt), 16'(cnt_exp(cnt)));
    $display("t=%0t %s A=%b B=%b Y=%b Y_q=%b rise=%b fall=%b hi_cnt=%0d",
             $time, tag, A, B, Y, Y_q, rise, fall, hi_cnt);
  endtask

  initial begin
    rst = 1'b1;
    A   = 2'b00;
    B   = 2'b00;
    #3;
    check_reg("reset", 2'b00, 2'b00, 2'b00, 0);

    // Truth table, combinational, while reset holds the registers.
    A = 2'b00; B = 2'b00; #5; check("tt00", 16'(Y), 16'(2'b00));
    A = 2'b11; B = 2'b00; #5; check("tt10", 16'(Y), 16'(2'b00));
    A = 2'b00; B = 2'b11; #5; check("tt01", 16'(Y), 16'(2'b00));
    A = 2'b11; B = 2'b11; #5; check("tt11", 16'(Y), 16'(2'b11));
    A = 2'b01; B = 2'b11; #5; check("lanes", 16'(Y), 16'(2'b01));
    A = 2'b01; B = 2'bx1; #5; check("xprop", 16'(Y), 16'(2'b01));
    A = 2'b00; B = 2'b00;
    step();
    rst = 1'b0;

    A = 2'b11; B = 2'b11;
    step(); check_reg("first_hi", 2'b11, 2'b11, 2'b00, 1);
    step(); check_reg("steady1", 2'b11, 2'b00, 2'b00, 2);
    B = 2'b10;
    step(); check_reg("fall_l0", 2'b10, 2'b00, 2'b01, 2);
    step(); check_reg("after_fall", 2'b10, 2'b00, 2'b00, 2);
    B = 2'b11;
    step(); check_reg("rise_l0", 2'b11, 2'b01, 2'b00, 3);
    step(); check_reg("cnt4", 2'b11, 2'b00, 2'b00, 4);
    step(); check_reg("cnt5", 2'b11, 2'b00, 2'b00, 5);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    check_reg("async_rst", 2'b00, 2'b00, 2'b00, 0);
    check("async_rst.Y", 16'(Y), 16'(2'b11));
    step(); check_reg("rst_held", 2'b00, 2'b00, 2'b00, 0);
    rst = 1'b0;
    step(); check_reg("release", 2'b11, 2'b11, 2'b00, 1);

    // Reset landing on an active fall pulse clears it.
    B = 2'b00;
    step(); check_reg("fall_both", 2'b00, 2'b00, 2'b11, 1);
    #2 rst = 1'b1;
    #1;
    check_reg("midpulse_rst", 2'b00, 2'b00, 2'b00, 0);
    step();
    rst = 1'b0;

    // Saturation: Y high for 10 edges.
    B = 2'b11;
    for (int i = 1; i <= 10; i++) begin
      step();
      check_reg($sformatf("sat%0d", i), 2'b11, (i == 1) ? 2'b11 : 2'b00, 2'b00, (i > 7) ? 7 : i);
    end

    // Toggle lane 1 every cycle; lane 0 stays high so the counter stays saturated.
    for (int i = 0; i < 4; i++) begin
      B = (i % 2 == 0) ? 2'b01 : 2'b11;
      step();
      check_reg($sformatf("tog%0d", i), (i % 2 == 0) ? 2'b01 : 2'b11,
                (i % 2 == 0) ? 2'b00 : 2'b10, (i % 2 == 0) ? 2'b10 : 2'b00, 7);
      check($sformatf("tog%0d.excl", i), 16'(rise & fall), 16'(2'b00));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
